fp8_int_to_fp: RTL and testbench

//   Multi-cycle converter from a signed two's-complement integer to FP8 E5M2,
//   the encode-side counterpart of the FP8 adder's unpack path. Feeds

---
 rtl/fp8_int_to_fp_pkg.sv | 24 ++
 rtl/fp8_int_to_fp_if.sv | 35 +++
 rtl/fp8_round_pack.sv | 40 ++++
 rtl/fp8_int_to_fp.sv | 113 +++++++++++
 tb/tb_fp8_int_to_fp.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp8_int_to_fp_pkg.sv
// Shared FP8 E5M2 definitions: field widths, exponent bias, rounding modes
// and the integer-to-FP8 converter state encoding.
package fp8_int_to_fp_pkg;

  localparam int FP8_E5M2_WIDTH     = 8;
  localparam int FP8_E5M2_EXP_WIDTH = 5;
  localparam int FP8_E5M2_MAN_WIDTH = 2;
  localparam int FP8_E5M2_BIAS      = 15;

  typedef enum logic [1:0] {
    ROUND_NEAREST,
    ROUND_UPWARD,
    ROUND_DOWNWARD,
    ROUND_ZERO
  } rounding_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } int2fp_state_t;

endpackage

// File: rtl/fp8_int_to_fp_if.sv
// Valid/ready bus for the integer-to-FP8 converter: integer operand in,
// packed E5M2 result out.
interface fp8_int_to_fp_if
  import fp8_int_to_fp_pkg::*;
#(
  parameter int INT_WIDTH = 16,
  parameter int WIDTH     = FP8_E5M2_WIDTH
);

  logic                 in_valid;
  logic                 in_ready;
  logic [INT_WIDTH-1:0] int_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     result;

  modport master (
    output in_valid,
    input  in_ready,
    output int_in,
    input  out_valid,
    output out_ready,
    input  result
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  int_in,
    output out_valid,
    input  out_ready,
    output result
  );

endinterface

// File: rtl/fp8_round_pack.sv
// Combinational round-and-pack stage for FP8 results: takes a normalised
// sign/exponent/mantissa with guard and sticky bits, applies the rounding
// mode, propagates a mantissa carry into the exponent and packs the fields.
module fp8_round_pack
  import fp8_int_to_fp_pkg::*;
#(
  parameter rounding_mode_t ROUNDING  = ROUND_NEAREST,
  parameter int             WIDTH     = FP8_E5M2_WIDTH,
  parameter int             EXP_WIDTH = FP8_E5M2_EXP_WIDTH,
  parameter int             MAN_WIDTH = FP8_E5M2_MAN_WIDTH
) (
  input  logic                 sign,
  input  logic [EXP_WIDTH-1:0] exp,
  input  logic [MAN_WIDTH-1:0] man,
  input  logic                 g,
  input  logic                 s,
  output logic [WIDTH-1:0]     packed_out
);

  logic                 inc;
  logic [MAN_WIDTH:0]   man_sum;
  logic [EXP_WIDTH-1:0] exp_out;

  // Increment decision for the selected rounding mode, then carry handling.
  always_comb begin
    inc = 1'b0;
    case (ROUNDING)
      ROUND_NEAREST:  inc = g && (s || man[0]);
      ROUND_UPWARD:   inc = (g || s) && !sign;
      ROUND_DOWNWARD: inc = (g || s) && sign;
      ROUND_ZERO:     inc = 1'b0;
      default:        inc = 1'b0;
    endcase
    man_sum = {1'b0, man} + {{MAN_WIDTH{1'b0}}, inc};
    // On carry-out the low mantissa bits are already zero: 1.11 + ulp = 10.00.
    exp_out = man_sum[MAN_WIDTH] ? exp + EXP_WIDTH'(1) : exp;
    packed_out = {sign, exp_out, man_sum[MAN_WIDTH-1:0]};
  end

endmodule

// File: rtl/fp8_int_to_fp.sv
// Multi-cycle signed integer to FP8 E5M2 converter. The magnitude is
// normalised one bit per cycle in a shift register, then rounded and packed.
//
//   state | meaning
//   IDLE  | ready for a new operand (in_ready)
//   NORM  | shifting magnitude left until its MSB is set, counting shifts
//   ROUND | leading one at MSB; round, pack and register the result
//   DONE  | result valid, held until out_ready
module fp8_int_to_fp
  import fp8_int_to_fp_pkg::*;
#(
  parameter rounding_mode_t ROUNDING  = ROUND_NEAREST,
  parameter int             INT_WIDTH = 16,
  parameter int             WIDTH     = FP8_E5M2_WIDTH,
  parameter int             EXP_WIDTH = FP8_E5M2_EXP_WIDTH,
  parameter int             MAN_WIDTH = FP8_E5M2_MAN_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  fp8_int_to_fp_if.slave   bus
);

  localparam int MSB     = INT_WIDTH - 1;
  localparam int CNT_W   = $clog2(INT_WIDTH);
  localparam int EXP_TOP = INT_WIDTH - 1 + FP8_E5M2_BIAS;
  // Bits below the leading one, padded so guard/sticky exist for tiny widths.
  localparam int LOW_W   = INT_WIDTH + MAN_WIDTH + 1;

  int2fp_state_t        state_q, state_d;
  logic                 sign_q;
  logic [INT_WIDTH-1:0] mag_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     result_q;

  logic [INT_WIDTH-1:0] abs_in;
  logic [LOW_W-1:0]     mag_low;
  logic [EXP_WIDTH-1:0] exp_biased;
  logic [MAN_WIDTH-1:0] man;
  logic                 g;
  logic                 s;
  logic [WIDTH-1:0]     packed_res;

  // Two's-complement magnitude; the most negative value maps to 2^(W-1).
  assign abs_in = bus.int_in[MSB] ? (~bus.int_in + INT_WIDTH'(1)) : bus.int_in;

  assign mag_low    = {mag_q[MSB-1:0], {(MAN_WIDTH + 2){1'b0}}};
  assign man        = mag_low[LOW_W-1 -: MAN_WIDTH];
  assign g          = mag_low[LOW_W-1-MAN_WIDTH];
  assign s          = |mag_low[LOW_W-2-MAN_WIDTH:0];
  assign exp_biased = EXP_WIDTH'(EXP_TOP) - EXP_WIDTH'(cnt_q);

  fp8_round_pack #(
    .ROUNDING  (ROUNDING),
    .WIDTH     (WIDTH),
    .EXP_WIDTH (EXP_WIDTH),
    .MAN_WIDTH (MAN_WIDTH)
  ) u_round_pack (
    .sign       (sign_q),
    .exp        (exp_biased),
    .man        (man),
    .g          (g),
    .s          (s),
    .packed_out (packed_res)
  );

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = (abs_in == '0) ? DONE : NORM;
      NORM:    if (mag_q[MSB]) state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, normalising shift/count and result register.
  always_ff @(posedge clock) begin
    if (reset) begin
      sign_q   <= 1'b0;
      mag_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          sign_q <= bus.int_in[MSB];
          mag_q  <= abs_in;
          cnt_q  <= '0;
          if (abs_in == '0) result_q <= '0;
        end
        NORM: if (!mag_q[MSB]) begin
          mag_q <= mag_q << 1;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        ROUND: result_q <= packed_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp8_int_to_fp.sv
// Bench for fp8_int_to_fp: four instances (one per rounding mode) run in
// lockstep on the same stimulus and are compared against an arithmetic
// reference model of integer-to-E5M2 conversion.
module tb_fp8_int_to_fp;
  import fp8_int_to_fp_pkg::*;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [15:0] int_in;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  fp8_int_to_fp_if #(.INT_WIDTH(16), .WIDTH(8)) bus_n ();
  fp8_int_to_fp_if #(.INT_WIDTH(16), .WIDTH(8)) bus_u ();
  fp8_int_to_fp_if #(.INT_WIDTH(16), .WIDTH(8)) bus_d ();
  fp8_int_to_fp_if #(.INT_WIDTH(16), .WIDTH(8)) bus_z ();

  assign bus_n.in_valid = in_valid;  assign bus_n.int_in = int_in;  assign bus_n.out_ready = out_ready;
  assign bus_u.in_valid = in_valid;  assign bus_u.int_in = int_in;  assign bus_u.out_ready = out_ready;
  assign bus_d.in_valid = in_valid;  assign bus_d.int_in = int_in;  assign bus_d.out_ready = out_ready;
  assign bus_z.in_valid = in_valid;  assign bus_z.int_in = int_in;  assign bus_z.out_ready = out_ready;

  fp8_int_to_fp #(.ROUNDING(ROUND_NEAREST),  .INT_WIDTH(16)) dut_n (.clock(clock), .reset(reset), .bus(bus_n));
  fp8_int_to_fp #(.ROUNDING(ROUND_UPWARD),   .INT_WIDTH(16)) dut_u (.clock(clock), .reset(reset), .bus(bus_u));
  fp8_int_to_fp #(.ROUNDING(ROUND_DOWNWARD), .INT_WIDTH(16)) dut_d (.clock(clock), .reset(reset), .bus(bus_d));
  fp8_int_to_fp #(.ROUNDING(ROUND_ZERO),     .INT_WIDTH(16)) dut_z (.clock(clock), .reset(reset), .bus(bus_z));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Mode index: 0 nearest-even, 1 upward, 2 downward, 3 toward zero.
  function automatic logic [7:0] dut_result(input int m);
    case (m)
      0:       return bus_n.result;
      1:       return bus_u.result;
      2:       return bus_d.result;
      default: return bus_z.result;
    endcase
  endfunction

  function automatic int floor_log2(input int a);
    int e = 0;
    while ((a >> (e + 1)) != 0) e++;
    return e;
  endfunction

  // Reference: |x| = q * 2^(e-2) + rem with q in [4,7]; round q by mode.
  function automatic logic [7:0] ref_fp8(input int x, input int mode);
    int  a, e, q, rem, half;
    bit  neg, inc;
    logic [4:0] ev;
    logic [1:0] mv;
    neg = (x < 0);
    a   = neg ? -x : x;
    if (a == 0) return 8'h00;
    e = floor_log2(a);
    if (e >= 2) begin
      q    = a >> (e - 2);
      rem  = a - (q << (e - 2));
      half = (e >= 3) ? (1 << (e - 3)) : 1;
    end else begin
      q    = a << (2 - e);
      rem  = 0;
      half = 1;
    end
    case (mode)
      0:       inc = (rem > half) || (rem != 0 && rem == half && (q % 2 == 1));
      1:       inc = (rem > 0) && !neg;
      2:       inc = (rem > 0) && neg;
      default: inc = 1'b0;
    endcase
    if (inc) q = q + 1;
    if (q == 8) begin
      q = 4;
      e = e + 1;
    end
    ev = 5'(e + 15);
    mv = 2'(q);
    return {neg, ev, mv};
  endfunction

  // Clock edges after the accept edge until out_valid is seen.
  function automatic int ref_latency(input int x);
    int a = (x < 0) ? -x : x;
    if (a == 0) return 0;
    return (15 - floor_log2(a)) + 2;
  endfunction

  task automatic start_and_wait(input logic [15:0] x, output int lat, output bit tmo);
    @(negedge clock);
    in_valid = 1'b1;
    int_in   = x;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!bus_n.out_valid && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
    end
    tmo = !bus_n.out_valid;
  endtask

  task automatic release_out();
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    int_in = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (bus_n.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b want 1", bus_n.in_ready);
    end
    checks++;
    if (bus_n.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b want 0", bus_n.out_valid);
    end
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (dut_result(m) !== 8'h00) begin
        errors++; $display("FAIL reset_result mode %0d got %h want 00", m, dut_result(m));
      end
    end
  endtask

  task automatic test_directed();
    logic [15:0] dx [11] = '{16'd1, 16'hFFFD, 16'd7, 16'd9, 16'd11, 16'd9, 16'hFFF7,
                             16'd11, 16'd32767, 16'h8000, 16'd0};
    int          dm [11] = '{0, 0, 0, 0, 0, 1, 1, 3, 0, 0, 0};
    logic [7:0]  de [11] = '{8'h3C, 8'hC2, 8'h47, 8'h48, 8'h4A, 8'h49, 8'hC8,
                             8'h49, 8'h78, 8'hF8, 8'h00};
    int lat;
    bit tmo;
    for (int i = 0; i < 11; i++) begin
      start_and_wait(dx[i], lat, tmo);
      checks++;
      if (tmo) begin
        errors++; $display("FAIL directed_timeout in %h no out_valid", dx[i]);
      end else begin
        checks++;
        if (dut_result(dm[i]) !== de[i]) begin
          errors++; $display("FAIL directed in %h mode %0d got %h want %h",
                             dx[i], dm[i], dut_result(dm[i]), de[i]);
        end
        checks++;
        if (lat != ref_latency(int'($signed(dx[i])))) begin
          errors++; $display("FAIL directed_latency in %h got %0d want %0d",
                             dx[i], lat, ref_latency(int'($signed(dx[i]))));
        end
      end
      release_out();
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    int xi, lat;
    bit tmo;
    logic [7:0] want;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       v = 16'($urandom_range(0, 40));
        1:       v = 16'(-int'($urandom_range(1, 300)));
        default: v = 16'($urandom);
      endcase
      xi = int'($signed(v));
      start_and_wait(v, lat, tmo);
      checks++;
      if (tmo) begin
        errors++; $display("FAIL random_timeout in %0d no out_valid", xi);
      end else begin
        for (int m = 0; m < 4; m++) begin
          want = ref_fp8(xi, m);
          checks++;
          if (dut_result(m) !== want) begin
            errors++; $display("FAIL random in %0d mode %0d got %h want %h",
                               xi, m, dut_result(m), want);
          end
        end
        checks++;
        if (lat != ref_latency(xi)) begin
          errors++; $display("FAIL random_latency in %0d got %0d want %0d",
                             xi, lat, ref_latency(xi));
        end
      end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit tmo;
    logic [7:0] want;
    start_and_wait(16'd9, lat, tmo);
    checks++;
    if (tmo) begin
      errors++; $display("FAIL bp_timeout no out_valid");
    end
    want = ref_fp8(9, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      in_valid = 1'b1;
      int_in   = 16'h1234;
      @(posedge clock);
      #1;
      checks++;
      if (bus_n.out_valid !== 1'b1 || bus_n.in_ready !== 1'b0 || bus_n.result !== want) begin
        errors++; $display("FAIL bp_hold cycle %0d got valid %b ready %b result %h want 1 0 %h",
                           c, bus_n.out_valid, bus_n.in_ready, bus_n.result, want);
      end
    end
    @(negedge clock);
    in_valid = 1'b0;
    release_out();
    checks++;
    if (bus_n.in_ready !== 1'b1 || bus_n.out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release got ready %b valid %b want 1 0",
                         bus_n.in_ready, bus_n.out_valid);
    end
    start_and_wait(16'hFFF7, lat, tmo);
    want = ref_fp8(-9, 0);
    checks++;
    if (tmo || bus_n.result !== want) begin
      errors++; $display("FAIL bp_next got %h timeout %b want %h", bus_n.result, tmo, want);
    end
    release_out();
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    @(negedge clock);
    in_valid = 1'b1;
    int_in   = 16'd1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (bus_n.in_ready !== 1'b1 || bus_n.out_valid !== 1'b0 || bus_n.result !== 8'h00) begin
      errors++; $display("FAIL reset_mid got ready %b valid %b result %h want 1 0 00",
                         bus_n.in_ready, bus_n.out_valid, bus_n.result);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (25) begin
      @(posedge clock);
      #1;
      if (bus_n.out_valid) seen = 1'b1;
    end
    checks++;
    if (seen || bus_n.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_stale got stale_valid %b ready %b want 0 1",
                         seen, bus_n.in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
